amiga_clk_en_gen: RTL and testbench
===================================

// Module: amiga_clk_en_gen
// PURPOSE
//  Parametrised clock-enable and reset sequencer for the single fast clock
//  domain, e.g. 28 MHz behind the PLL/DLL.
//  Replaces free-running ripple dividers (the old 2-bit /4 for 7 MHz) with
//  NUM_CH phase-programmable one-cycle enables, such as 7 MHz CCK and CCK_n.
//  Holds everything in reset until the PLL lock is stable for LOCK_DELAY cycles.
//  Sits directly after the clock primitives; feeds the chipset, CPU bridge and SDRAM control.
// PARAMETERS
//  NUM_CH      3     number of enable channels
//  CNT_W       4     channel counter width; period = div+1, 1..2**CNT_W
//  LOCK_DELAY  1024  cycles locked_s must stay high before reset release (>=2)
//  DLY_W       11    width of the lock-delay counter (>= clog2(LOCK_DELAY)+1)
// PORTS
//  clk       in   1               single clock; all logic on posedge
//  areset    in   1               asynchronous, active-high reset
//  locked    in   1               PLL/DLL lock, asynchronous to clk
//  div       in   NUM_CH*CNT_W    per-channel period-1; ch i = div[i*CNT_W +: CNT_W]
//  phase     in   NUM_CH*CNT_W    per-channel fire slot, packed like div
//  sync_in   in   1               realign pulse; restarts all channels at slot 0
//  en        out  NUM_CH          one-cycle clock enables
//  rst_out   out  1               synchronous-deassert reset to downstream logic
//  running   out  1               high in RUN state
//  cfg_err   out  NUM_CH          shadow phase > shadow div (channel can never fire)
// BEHAVIOUR
//  - Reset values while areset: en=0, rst_out=1, running=0, cfg_err=0,
//    FSM=WAIT_LOCK, all counters and shadow registers 0.
//  - locked passes a 2-flop synchroniser -> locked_s.
//    All FSM decisions use locked_s only.
//  - FSM transitions:
//    WAIT_LOCK -> COUNT when locked_s=1; delay counter cleared.
//    COUNT: delay counter increments each cycle.
//      locked_s=0 -> WAIT_LOCK, counter cleared.
//      Counter = LOCK_DELAY-1 -> RUN.
//    RUN: locked_s=0 -> WAIT_LOCK.
//  - Outputs by state:
//    WAIT_LOCK, COUNT: rst_out=1, en=0, running=0.
//    RUN: rst_out=0, running=1.
//  - Reset release timing: rst_out falls exactly LOCK_DELAY cycles after the
//    first cycle with locked_s=1, provided locked_s never drops in between.
//  - Lock loss in RUN: rst_out=1 and en=0 from the next cycle. No partial enable
//    pulse is emitted after that.
//  - Channel slot numbering: the first cycle with rst_out=0 is slot 0, and every
//    channel counter is 0 there.
//    Counter i increments each cycle and wraps from div_sh[i] to 0.
//  - Enable rule: en[i]=1 exactly in cycles where counter i == phase_sh[i].
//    en is a registered output, so implement with one-cycle lookahead.
//  - div_sh=0 means en[i] is continuously 1, provided phase_sh=0.
//  - Shadow load: div/phase are loaded into div_sh/phase_sh at each of:
//    - entry to RUN;
//    - counter i wrap (cnt==div_sh, per channel);
//    - sync_in.
//    A mid-period change therefore never produces a short or double pulse.
//  - cfg_err[i] = (phase_sh[i] > div_sh[i]), registered. In that case en[i] stays 0.
//  - sync_in=1 in RUN: next cycle is slot 0 for all channels, and shadows reload.
//    This overrides wrap in the same cycle.
//    en in the next cycle follows the new shadows (phase_sh=0 fires).
//    sync_in is ignored outside RUN.
//  - areset asserted at any time (mid-COUNT, mid-period) returns all state to the
//    reset values asynchronously. Deassertion is synchronised internally with 2 flops.
// STRUCTURE
//  - Shared include amiga_clk_defs.vh holds:
//    - FSM state encodings (WAIT_LOCK=2'd0, COUNT=2'd1, RUN=2'd2);
//    - default LOCK_DELAY;
//    - standard div/phase constants: CCK div=3 phase=0, CCK_n div=3 phase=2.
//  - Sub-module amiga_clk_en_chan, instantiated NUM_CH times via generate.
//    Contents: counter, shadow registers, lookahead compare, en/cfg_err flops.
//    Inputs: run, start (RUN entry or sync), div, phase.
//  - Top level contains the synchronisers, the FSM and the delay counter.
// TESTING
//  1 Baseline: LOCK_DELAY=16; locked rises at t0.
//    -> rst_out falls at t0+2(sync)+16.
//    -> en[0] (div=3 phase=0) fires at slots 0,4,8.
//    -> en[1] (div=3 phase=2) fires at slots 2,6,10.
//  2 Lock glitch: locked low for 1 cycle during COUNT.
//    -> delay counter restarts; rst_out fall is delayed by the full 16 cycles.
//    Locked drop in RUN -> rst_out=1 and en=0 from the next cycle.
//  3 Runtime change: div[0] changes 3->1 at slot 1.
//    -> the next pulse stays at slot 4; later pulses at 6, 8.
//    -> never two pulses closer than 2 cycles.
//  4 Sync: sync_in pulse at slot 5 with div=3.
//    -> slot 0 on the next cycle, en[0]=1 there.
//    -> next en[0] 4 cycles later.
//  5 Edge config: div=0 phase=0 -> en high every RUN cycle.
//    div=2 phase=3 -> cfg_err=1, en stays 0.
//  6 areset asserted mid-period with en[1]=1 -> en=0 and rst_out=1 immediately.
//    After release, the full lock sequence repeats.

Source files
------------

// File: rtl/amiga_clk_en_gen_pkg.sv
// Shared definitions for the clock-enable / reset sequencer: FSM encoding,
// default lock delay and the standard 7 MHz CCK / CCK_n divider settings.
package amiga_clk_en_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int LOCK_DELAY_DEF = 1024;

  localparam int CCK_DIV    = 3;
  localparam int CCK_PHASE  = 0;
  localparam int CCKN_DIV   = 3;
  localparam int CCKN_PHASE = 2;

endpackage

// File: rtl/amiga_clk_en_gen_chan.sv
// One enable channel: slot counter, shadowed div/phase and a registered
// enable computed one cycle ahead from the next-cycle counter and shadows.
module amiga_clk_en_gen_chan #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_phase,
  output logic             o_en,
  output logic             o_cfg_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_sh;
  logic [CNT_W-1:0] r_phase_sh;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic             w_reload;

  // Next-cycle slot and shadows; start (RUN entry or sync) wins over wrap.
  always_comb begin
    w_reload    = i_start | (r_cnt == r_div_sh);
    w_cnt_nxt   = '0;
    w_div_nxt   = '0;
    w_phase_nxt = '0;
    if (!i_run) begin
      w_cnt_nxt   = '0;
      w_div_nxt   = '0;
      w_phase_nxt = '0;
    end else if (w_reload) begin
      w_cnt_nxt   = '0;
      w_div_nxt   = i_div;
      w_phase_nxt = i_phase;
    end else begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_div_nxt   = r_div_sh;
      w_phase_nxt = r_phase_sh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div_sh   <= '0;
      r_phase_sh <= '0;
      o_en       <= 1'b0;
      o_cfg_err  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div_sh   <= w_div_nxt;
      r_phase_sh <= w_phase_nxt;
      o_en       <= i_run & (w_cnt_nxt == w_phase_nxt);
      o_cfg_err  <= i_run & (w_phase_nxt > w_div_nxt);
    end
  end

endmodule

// File: rtl/amiga_clk_en_gen.sv
// Clock-enable and reset sequencer: reset/lock synchronisers, lock-delay FSM
// and NUM_CH phase-programmable one-cycle enable channels.
module amiga_clk_en_gen
  import amiga_clk_en_gen_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int CNT_W      = 4,
  parameter int LOCK_DELAY = LOCK_DELAY_DEF,
  parameter int DLY_W      = 11
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    locked,
  input  logic [NUM_CH*CNT_W-1:0] div,
  input  logic [NUM_CH*CNT_W-1:0] phase,
  input  logic                    sync_in,
  output logic [NUM_CH-1:0]       en,
  output logic                    rst_out,
  output logic                    running,
  output logic [NUM_CH-1:0]       cfg_err
);

  // Counter reaches LOCK_DELAY-1 on the same edge the FSM enters RUN.
  localparam logic [DLY_W-1:0] LP_DLY_LAST = DLY_W'(LOCK_DELAY - 2);

  logic [1:0]       r_rst_sync;
  logic [1:0]       r_lock_sync;
  logic             w_rst;
  logic             w_locked_s;
  state_t           r_state;
  logic [DLY_W-1:0] r_dly_cnt;
  logic             w_go_run;
  logic             w_run_nxt;
  logic             w_start;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[1];

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], locked};
    end
  end

  assign w_locked_s = r_lock_sync[1];

  // Lookahead: channels need to know whether the next cycle is RUN / slot 0.
  always_comb begin
    w_go_run  = (r_state == COUNT) & w_locked_s & (r_dly_cnt == LP_DLY_LAST);
    w_run_nxt = w_locked_s & ((r_state == RUN) | w_go_run);
    w_start   = w_run_nxt & (w_go_run | sync_in);
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state   <= WAIT_LOCK;
      r_dly_cnt <= '0;
      rst_out   <= 1'b1;
      running   <= 1'b0;
    end else begin
      rst_out <= ~w_run_nxt;
      running <= w_run_nxt;
      case (r_state)
        WAIT_LOCK: begin
          r_dly_cnt <= '0;
          if (w_locked_s) begin
            r_state <= COUNT;
          end else begin
            r_state <= WAIT_LOCK;
          end
        end
        COUNT: begin
          if (!w_locked_s) begin
            r_state   <= WAIT_LOCK;
            r_dly_cnt <= '0;
          end else if (w_go_run) begin
            r_state   <= RUN;
            r_dly_cnt <= r_dly_cnt + DLY_W'(1);
          end else begin
            r_state   <= COUNT;
            r_dly_cnt <= r_dly_cnt + DLY_W'(1);
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state   <= WAIT_LOCK;
            r_dly_cnt <= '0;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state   <= WAIT_LOCK;
          r_dly_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    amiga_clk_en_gen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (w_rst),
      .i_run    (w_run_nxt),
      .i_start  (w_start),
      .i_div    (div[g*CNT_W +: CNT_W]),
      .i_phase  (phase[g*CNT_W +: CNT_W]),
      .o_en     (en[g]),
      .o_cfg_err(cfg_err[g])
    );
  end

endmodule

// File: tb/tb_amiga_clk_en_gen.sv
// Directed bench for amiga_clk_en_gen with a cycle-level reference model
// (lock-run length and absolute-cycle period bases) checked every cycle.
module tb_amiga_clk_en_gen;
  import amiga_clk_en_gen_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 4;
  localparam int LD  = 16;

  logic            clk = 1'b0;
  logic            areset = 1'b0;
  logic            locked = 1'b0;
  logic            sync_in = 1'b0;
  logic [NCH*CW-1:0] div = '0;
  logic [NCH*CW-1:0] phase = '0;
  logic [NCH-1:0]  en;
  logic [NCH-1:0]  cfg_err;
  logic            rst_out;
  logic            running;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  amiga_clk_en_gen #(
    .NUM_CH    (NCH),
    .CNT_W     (CW),
    .LOCK_DELAY(LD),
    .DLY_W     (11)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .locked (locked),
    .div    (div),
    .phase  (phase),
    .sync_in(sync_in),
    .en     (en),
    .rst_out(rst_out),
    .running(running),
    .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_cyc = 0;
  logic         m_ar1 = 1'b0, m_ar2 = 1'b0;
  logic         m_l1 = 1'b0, m_ls = 1'b0;
  int           m_lr = 0;
  logic         m_run = 1'b0;
  int           m_base [NCH];
  int           m_div  [NCH];
  int           m_ph   [NCH];
  logic [NCH-1:0] m_en = '0;
  logic [NCH-1:0] m_cfg = '0;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_base[i] = 0; m_div[i] = 0; m_ph[i] = 0;
    end
  end

  always @(negedge clk) begin : model
    logic rs;
    logic nrun;
    logic st;
    int   nlr;
    rs = areset | m_ar1 | m_ar2;
    chk("cyc_en",      en,      rs ? 32'd0 : 32'(m_en));
    chk("cyc_rst_out", rst_out, rs ? 32'd1 : 32'(!m_run));
    chk("cyc_running", running, rs ? 32'd0 : 32'(m_run));
    chk("cyc_cfg_err", cfg_err, rs ? 32'd0 : 32'(m_cfg));
    if (rs) begin
      m_l1 = 1'b0; m_ls = 1'b0; m_lr = 0; m_run = 1'b0; m_en = '0; m_cfg = '0;
      for (int i = 0; i < NCH; i++) begin
        m_base[i] = 0; m_div[i] = 0; m_ph[i] = 0;
      end
    end else begin
      nlr  = m_ls ? ((m_lr < LD) ? m_lr + 1 : LD) : 0;
      nrun = (nlr >= LD);
      st   = nrun & (!m_run | sync_in);
      for (int i = 0; i < NCH; i++) begin
        if (!nrun) begin
          m_base[i] = 0; m_div[i] = 0; m_ph[i] = 0;
        end else if (st || (m_cyc - m_base[i] == m_div[i])) begin
          m_base[i] = m_cyc + 1;
          m_div[i]  = int'(div[i*CW +: CW]);
          m_ph[i]   = int'(phase[i*CW +: CW]);
        end
        m_en[i]  = nrun && ((m_cyc + 1 - m_base[i]) == m_ph[i]);
        m_cfg[i] = nrun && (m_ph[i] > m_div[i]);
      end
      m_lr  = nlr;
      m_run = nrun;
      m_ls  = m_l1;
      m_l1  = locked;
    end
    m_ar2 = m_ar1;
    m_ar1 = areset;
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Count cycles (from the current one) until rst_out reaches lvl, bounded.
  task automatic wait_rst(input logic lvl, input int lim, output int n);
    n = 0;
    smp();
    while (rst_out !== lvl && n < lim) begin
      cyc();
      smp();
      n++;
    end
  endtask

  task automatic wait_en(input int ch, input int lim, output logic found);
    int k;
    k = 0;
    found = 1'b0;
    while (!found && k < lim) begin
      cyc();
      smp();
      found = en[ch];
      k++;
    end
  endtask

  initial begin : stim
    int          n;
    logic        found;
    logic [11:0] r0, r1, r2;
    logic [8:0]  r3;
    logic [5:0]  s0, s1;
    logic        acc;

    #0 areset = 1'b1;
    div   = {CW'(0), CW'(CCKN_DIV), CW'(CCK_DIV)};
    phase = {CW'(0), CW'(CCKN_PHASE), CW'(CCK_PHASE)};
    repeat (3) cyc();
    smp();
    chk("reset_en", en, 32'd0);
    chk("reset_rst_out", rst_out, 32'd1);
    chk("reset_running", running, 32'd0);
    chk("reset_cfg_err", cfg_err, 32'd0);
    cyc();
    areset = 1'b0;
    repeat (4) cyc();

    // Baseline release and slot pattern
    locked = 1'b1;
    wait_rst(1'b0, 100, n);
    chk("t1_release_cycles", n, 32'd18);
    chk("t1_running", running, 32'd1);
    r0 = '0; r1 = '0; r2 = '0;
    for (int s = 0; s < 12; s++) begin
      if (s > 0) begin
        cyc();
        smp();
      end
      r0[s] = en[0]; r1[s] = en[1]; r2[s] = en[2];
    end
    chk("t1_en0_slots", r0, 32'h111);
    chk("t1_en1_slots", r1, 32'h444);
    chk("t1_en2_slots", r2, 32'hFFF);

    // Runtime div change 3->1 at slot 1
    wait_en(0, 20, found);
    chk("t3_pulse_found", found, 32'd1);
    r3 = '0;
    r3[0] = en[0];
    for (int s = 1; s < 9; s++) begin
      cyc();
      if (s == 1) div[CW-1:0] = CW'(1);
      smp();
      r3[s] = en[0];
    end
    chk("t3_en0_slots", r3, 32'h151);
    cyc();
    div[CW-1:0] = CW'(CCK_DIV);
    repeat (6) cyc();

    // sync_in at slot 5 of a div=3 sequence
    wait_en(0, 20, found);
    chk("t4_pulse_found", found, 32'd1);
    repeat (4) cyc();
    cyc();
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    s0 = '0; s1 = '0;
    for (int s = 0; s < 6; s++) begin
      if (s > 0) cyc();
      smp();
      s0[s] = en[0]; s1[s] = en[1];
    end
    chk("t4_en0_after_sync", s0, 32'h11);
    chk("t4_en1_after_sync", s1, 32'h04);

    // Unreachable phase on channel 2
    cyc();
    div[2*CW +: CW]   = CW'(2);
    phase[2*CW +: CW] = CW'(3);
    repeat (3) cyc();
    smp();
    chk("t5_cfg_err", cfg_err, 32'h4);
    acc = 1'b0;
    repeat (8) begin
      cyc();
      smp();
      acc = acc | en[2];
    end
    chk("t5_en2_silent", acc, 32'd0);

    // Lock loss in RUN
    cyc();
    locked = 1'b0;
    wait_rst(1'b1, 20, n);
    chk("t2_loss_cycles", n, 32'd3);
    chk("t2_loss_en", en, 32'd0);
    chk("t2_loss_running", running, 32'd0);

    // One-cycle lock glitch during COUNT
    cyc();
    div[2*CW +: CW]   = CW'(0);
    phase[2*CW +: CW] = CW'(0);
    locked = 1'b1;
    n = 0;
    smp();
    while (rst_out !== 1'b0 && n < 60) begin
      cyc();
      n++;
      if (n == 10) locked = 1'b0;
      if (n == 11) locked = 1'b1;
      smp();
    end
    chk("t2_glitch_release", n, 32'd29);

    // Asynchronous reset while en[1] is high
    wait_en(1, 20, found);
    chk("t6_en1_found", found, 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("t6_async_en", en, 32'd0);
    chk("t6_async_rst_out", rst_out, 32'd1);
    chk("t6_async_running", running, 32'd0);
    cyc();
    cyc();
    areset = 1'b0;
    wait_rst(1'b0, 100, n);
    chk("t6_release_cycles", n, 32'd20);
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
